// File: rtl/shifter_unit_pkg.sv
// Shared op encodings for the ALU shifter unit.
package shifter_unit_pkg;

    typedef logic [1:0] shift_op_t;

    localparam shift_op_t SHIFT_OP_SLL = 2'b00;
    localparam shift_op_t SHIFT_OP_SRL = 2'b01;
    localparam shift_op_t SHIFT_OP_SRA = 2'b10;
    localparam shift_op_t SHIFT_OP_ROR = 2'b11;

endpackage

// File: rtl/shifter_core.sv
// Combinational log2 barrel shifter: one mux stage per shift-amount bit,
// with op and fill bit supplied by the wrapper.
module shifter_core
    import shifter_unit_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int SHIFT_AMOUNT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic [SHIFT_AMOUNT_WIDTH-1:0] amount_i,
    input  shift_op_t                     op_i,
    input  logic                          fill_i,
    output logic [DATA_WIDTH-1:0]         result_o
);

    localparam logic [DATA_WIDTH-1:0] ONES = '1;

    logic [DATA_WIDTH-1:0] stage;
    logic [DATA_WIDTH-1:0] shl, shr, rot;

    // Stage k moves by 2**k; shifts of DATA_WIDTH or more naturally flush to
    // the fill value, and rotates use the distance modulo DATA_WIDTH.
    always_comb begin
        stage = data_i;
        shl   = '0;
        shr   = '0;
        rot   = '0;
        for (int k = 0; k < SHIFT_AMOUNT_WIDTH; k++) begin
            shl = stage << (1 << k);
            shr = (stage >> (1 << k)) | (fill_i ? ~(ONES >> (1 << k)) : '0);
            rot = (stage >> ((1 << k) % DATA_WIDTH))
                | (stage << (DATA_WIDTH - ((1 << k) % DATA_WIDTH)));
            if (amount_i[k]) begin
                case (op_i)
                    SHIFT_OP_SLL: stage = shl;
                    SHIFT_OP_ROR: stage = rot;
                    default:      stage = shr;
                endcase
            end
        end
        result_o = stage;
    end

endmodule

// File: rtl/shifter_unit.sv
// Registered barrel shifter (SLL/SRL/SRA, ROR when SHIFTER_ROTATE_EN is
// defined, otherwise op 11 yields zero). One-cycle latency, no backpressure.
module shifter_unit
    import shifter_unit_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int SHIFT_AMOUNT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         data,
    input  logic [SHIFT_AMOUNT_WIDTH-1:0] shift_amount,
    input  shift_op_t                     shift_op,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         result,
    output logic                          zero
);

`ifdef SHIFTER_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic                  fill;
    logic [DATA_WIDTH-1:0] core_res;
    logic [DATA_WIDTH-1:0] result_d, result_q;
    logic                  zero_q;
    logic                  vld_q;

    assign fill = (shift_op == SHIFT_OP_SRA) & data[DATA_WIDTH-1];

    shifter_core #(
        .DATA_WIDTH        (DATA_WIDTH),
        .SHIFT_AMOUNT_WIDTH(SHIFT_AMOUNT_WIDTH)
    ) u_core (
        .data_i  (data),
        .amount_i(shift_amount),
        .op_i    (shift_op),
        .fill_i  (fill),
        .result_o(core_res)
    );

    always_comb begin
        result_d = core_res;
        if (!ROT_EN && shift_op == SHIFT_OP_ROR) result_d = '0;
    end

    // Result and zero only move on accepted ops; otherwise they hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            vld_q    <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                result_q <= result_d;
                zero_q   <= (result_d == '0);
            end
        end
    end

    assign out_valid = vld_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_shifter_unit.sv
// Self-checking bench for shifter_unit: directed table, pipeline/reset
// scenarios and random stimulus against a per-bit reference model.
module tb_shifter_unit;
    localparam int W   = 8;
    localparam int SAW = $clog2(W);

    logic           clk = 1'b0;
    logic           rst, in_valid;
    logic [W-1:0]   data;
    logic [SAW-1:0] shift_amount;
    logic [1:0]     shift_op;
    logic           out_valid;
    logic [W-1:0]   result;
    logic           zero;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] m_res;
    logic         m_zero, m_vld;

    always #5 clk = ~clk;

    shifter_unit #(.DATA_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .data        (data),
        .shift_amount(shift_amount),
        .shift_op    (shift_op),
        .out_valid   (out_valid),
        .result      (result),
        .zero        (zero)
    );

    // Each output bit is taken from where the op says it comes from.
    function automatic logic [W-1:0] ref_shift(logic [W-1:0] d, int amt, logic [1:0] op);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            case (op)
                2'd0: if (i - amt >= 0) r[i] = d[i-amt];
                2'd1: if (i + amt < W)  r[i] = d[i+amt];
                2'd2: r[i] = (i + amt < W) ? d[i+amt] : d[W-1];
                default: begin
`ifdef SHIFTER_ROTATE_EN
                    r[i] = d[(i + amt) % W];
`else
                    r[i] = 1'b0;
`endif
                end
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [W-1:0] d,
                        input logic [SAW-1:0] a, input logic [1:0] op);
        rst = r; in_valid = v; data = d; shift_amount = a; shift_op = op;
        @(posedge clk);
        if (r) begin
            m_res = '0; m_zero = 1'b1; m_vld = 1'b0;
        end else begin
            m_vld = v;
            if (v) begin
                m_res  = ref_shift(d, int'(a), op);
                m_zero = (m_res == '0);
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_vld));
        chk("result",    32'(result),    32'(m_res));
        chk("zero",      32'(zero),      32'(m_zero));
    endtask

    typedef struct {
        logic [W-1:0]   d;
        logic [SAW-1:0] a;
        logic [1:0]     op;
        logic [W-1:0]   exp;
    } vec_t;

    vec_t dir[$];

    initial begin
        vec_t v;
        int   cnt;
        logic [W-1:0] last;

        rst = 1'b1; in_valid = 1'b0; data = '0; shift_amount = '0; shift_op = '0;

        // Reset state
        step(1'b1, 1'b0, '0, '0, 2'd0);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_zero",   32'(zero),   32'h1);
        chk("rst_valid",  32'(out_valid), 32'h0);

        // Directed vectors with hand-derived results
        dir.push_back('{8'b00001111, 3'd1, 2'd0, 8'b00011110});
        dir.push_back('{8'b11110000, 3'd2, 2'd0, 8'b11000000});
        dir.push_back('{8'b10101010, 3'd0, 2'd0, 8'b10101010});
        dir.push_back('{8'b10101010, 3'd7, 2'd0, 8'b00000000});
        dir.push_back('{8'b00001111, 3'd1, 2'd1, 8'b00000111});
        dir.push_back('{8'b11110000, 3'd2, 2'd1, 8'b00111100});
        dir.push_back('{8'b10101010, 3'd7, 2'd1, 8'b00000001});
        dir.push_back('{8'b00000000, 3'd7, 2'd1, 8'b00000000});
        dir.push_back('{8'b10001111, 3'd1, 2'd2, 8'b11000111});
        dir.push_back('{8'b11110000, 3'd2, 2'd2, 8'b11111100});
        dir.push_back('{8'b00101010, 3'd0, 2'd2, 8'b00101010});
        dir.push_back('{8'b10101010, 3'd7, 2'd2, 8'b11111111});
`ifdef SHIFTER_ROTATE_EN
        dir.push_back('{8'b10000001, 3'd1, 2'd3, 8'b11000000});
`else
        dir.push_back('{8'b10000001, 3'd1, 2'd3, 8'b00000000});
`endif
        foreach (dir[i]) begin
            v = dir[i];
            step(1'b0, 1'b1, v.d, v.a, v.op);
            chk($sformatf("dir%0d_result", i), 32'(result), 32'(v.exp));
            chk($sformatf("dir%0d_zero", i),   32'(zero),   32'(v.exp == '0));
        end

        // Pipeline: three back-to-back ops, then idle
        step(1'b0, 1'b0, '0, '0, 2'd0);
        cnt = 0;
        step(1'b0, 1'b1, 8'h81, 3'd3, 2'd0); cnt += int'(out_valid);
        step(1'b0, 1'b1, 8'h81, 3'd3, 2'd1); cnt += int'(out_valid);
        step(1'b0, 1'b1, 8'h81, 3'd3, 2'd2); cnt += int'(out_valid);
        last = result;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, $urandom(), $urandom(), $urandom());
            cnt += int'(out_valid);
            chk("pipe_hold", 32'(result), 32'(last));
        end
        chk("pipe_count", 32'(cnt), 32'd3);
        chk("pipe_last",  32'(last), 32'hF0);

        // Reset beats a simultaneous valid input, which is dropped
        step(1'b0, 1'b1, 8'h0F, 3'd1, 2'd0);
        step(1'b1, 1'b1, 8'hFF, 3'd1, 2'd0);
        chk("rstpri_valid",  32'(out_valid), 32'h0);
        chk("rstpri_result", 32'(result),    32'h0);
        chk("rstpri_zero",   32'(zero),      32'h1);
        step(1'b0, 1'b0, 8'hFF, 3'd1, 2'd0);
        chk("rstdrop_result", 32'(result), 32'h0);
        step(1'b0, 1'b1, 8'h03, 3'd2, 2'd0);
        chk("rstfirst_result", 32'(result), 32'h0C);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                 W'($urandom()), SAW'($urandom()), 2'($urandom()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shifter_unit.md
# shifter_unit

Registered, parameterised barrel shifter for the parameterised ALU datapath. It performs a logical left shift, logical right shift, arithmetic right shift, or optional rotate right on one operand. The shift distance comes from a separate shift-amount field. The result is registered with a one-cycle valid pipeline and sits alongside the adder/logic units feeding the ALU result mux.

## Interface
- DATA_WIDTH, 8: operand and result width in bits; must be ≥2.
- SHIFT_AMOUNT_WIDTH, $clog2(DATA_WIDTH): width of the shift-amount field.
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- in_valid, input, 1: the operand, amount and op are valid this cycle.
- data, input, DATA_WIDTH: operand to shift.
- shift_amount, input, SHIFT_AMOUNT_WIDTH: unsigned shift distance, 0..2^SHIFT_AMOUNT_WIDTH-1.
- shift_op, input, 2: 00 = SLL, 01 = SRL, 10 = SRA, 11 = ROR (or reserved, see Configuration).
- out_valid, output, 1: result is the answer to the operation accepted one cycle earlier.
- result, output, DATA_WIDTH: registered shift result.
- zero, output, 1: registered flag, high when result is all zeros.

## Operation
- SLL: result = data << shift_amount, zero-filled from the LSB.
- SRL: result = data >> shift_amount, zero-filled from the MSB.
- SRA: result = data >>> shift_amount; data[DATA_WIDTH-1] is the sign bit and is replicated into vacated MSBs.
- ROR (when enabled): bits shifted out at the LSB re-enter at the MSB; the amount is taken modulo DATA_WIDTH.
- shift_amount = 0: result = data for every op.
- shift_amount ≥ DATA_WIDTH (possible only for non-power-of-2 widths):
  - SLL/SRL give all zeros.
  - SRA gives all copies of the sign bit.
- All arithmetic is unsigned except the SRA fill bit. No carry or overflow output.
- zero is computed from the newly registered result, in the same cycle as result.

## Timing
- Latency is exactly 1 cycle: inputs sampled at edge N with in_valid=1 give result, zero and out_valid=1 after edge N.
- in_valid=0 at an edge:
  - out_valid goes to 0 after that edge.
  - result and zero hold their previous values.
- Throughput is one operation per cycle; there is no backpressure and no stall input.
- Back-to-back valid inputs each produce their own result on consecutive cycles.
- rst=1 at an edge:
  - result and zero load 0 and 1 respectively; out_valid loads 0.
  - Reset takes priority over a simultaneous in_valid=1, and that input is dropped.
- Reset mid-stream cancels the in-flight output. The first valid result after reset appears one cycle after the first accepted input.

## Configuration
- SHIFTER_ROTATE_EN:
  - Defined: shift_op=11 performs ROR.
  - Undefined: shift_op=11 is reserved and produces result = 0 (zero = 1, out_valid still follows in_valid).
- The other three ops are identical in both builds.

## Structure
- The shared package holds:
  - the op encodings SHIFT_OP_SLL=2'b00, SHIFT_OP_SRL=2'b01, SHIFT_OP_SRA=2'b10, SHIFT_OP_ROR=2'b11;
  - a 2-bit shift_op_t typedef.
- Sub-module shifter_core is combinational with no clock. It is a log2 barrel shifter with one mux stage per shift_amount bit, taking the fill bit and op as controls.
- shifter_unit wraps shifter_core with the input decode, the zero detect and the output/valid registers.

## Test plan
- SLL, DATA_WIDTH=8:
  - 00001111 by 1 -> 00011110
  - 11110000 by 2 -> 11000000
  - 10101010 by 0 -> 10101010
  - 10101010 by 7 -> 00000000 with zero=1
- SRL:
  - 00001111 by 1 -> 00000111
  - 11110000 by 2 -> 00111100
  - 10101010 by 7 -> 00000001
  - 00000000 by 7 -> 00000000 with zero=1
- SRA:
  - 10001111 by 1 -> 11000111
  - 11110000 by 2 -> 11111100
  - 00101010 by 0 -> 00101010
  - 10101010 by 7 -> 11111111
- Op 11:
  - With SHIFTER_ROTATE_EN, 10000001 by 1 -> 11000000.
  - Without it, the same input -> 00000000 with zero=1.
- Pipeline: three back-to-back valid ops then in_valid=0 -> out_valid high for exactly 3 cycles, each result one cycle after its input; result holds the last value afterwards.
- Reset: assert rst together with in_valid=1 -> next cycle out_valid=0, result=0, zero=1; the dropped op never appears.
